cam_match_resolver: RTL and testbench
=====================================

Name: cam_match_resolver

Overview:
- Sits directly downstream of the CAM row array.
- Collects the per-row match lines from NUM_ROWS rows into one search-result vector and captures it on a valid/ready handshake.
- Walks the captured vector lowest-row-first, emitting one matching row address per output handshake. Row 0 has the highest priority.
- Reports the total match count and a last-beat flag, so the lookup/update logic downstream can consume single-match or multi-match results.

Parameters:
- NUM_ROWS, 16: number of CAM rows, which is also the width of the match vector. Legal range 2..256.
- ADDR_W, 4: width of the row address. Must satisfy 2^ADDR_W >= NUM_ROWS.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- match_in_valid, input, 1: row_match_vec holds a settled search result.
- row_match_vec, input, NUM_ROWS: bit i is row i's row_match output.
- in_ready, output, 1: block will capture row_match_vec this cycle.
- out_valid, output, 1: result beat present.
- out_ready, input, 1: downstream accepts the result beat.
- match_addr, output, ADDR_W: row index of the current matching row.
- match_found, output, 1: the captured vector had at least one bit set.
- match_count, output, ADDR_W+1: popcount of the captured vector.
- last, output, 1: the current beat is the final beat of this result.

Behaviour:
- State machine has two states:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; pending vector, match_addr, match_count, match_found and last all go to 0; out_valid=0.
  - in_ready is forced to 0 while rst=0 and becomes 1 in the first cycle after deassertion.
- Reset mid-burst discards the remaining pending bits; no further beat is produced.
- Capture:
  - Happens in IDLE when match_in_valid=1 and in_ready=1.
  - pending <= row_match_vec; match_count <= popcount(row_match_vec); next state is EMIT.
  - Latency: out_valid rises exactly 1 cycle after the capture edge.
  - match_in_valid outside IDLE is ignored; no capture, no error.
- EMIT outputs are all derived from registers; there is no combinational path from any input to any output.
  - match_addr = index of the lowest set bit of pending.
  - match_found = OR of pending.
  - last = 1 when pending has 0 or 1 bits set.
- Handshake in EMIT:
  - A beat transfers when out_valid=1 and out_ready=1.
  - On transfer, the lowest set bit of pending is cleared.
  - If last=1, the next state is IDLE; otherwise stay in EMIT.
- Stall: while out_ready=0, all outputs and pending hold stable; out_valid never drops without a transfer.
- No-match case: the captured vector is all zero. The block emits exactly one beat: match_found=0, match_addr=0, match_count=0, last=1. It returns to IDLE when that beat is accepted.
- match_count and match_found-of-capture are constant across all beats of one result.
- match_found stays 1 on every beat of a non-empty result.
- Back-to-back results:
  - The earliest next capture is the cycle after the last beat transfers, when IDLE is re-entered.
  - Minimum period is 2 cycles for a single-beat result, and k+1 cycles for k matches with out_ready held at 1.
- Full vector (all NUM_ROWS bits set): NUM_ROWS beats with addresses 0..NUM_ROWS-1 in order; match_count=NUM_ROWS. This is why match_count is ADDR_W+1 bits wide.
- When 2^ADDR_W > NUM_ROWS, the unused address values are never produced.

Test Plan:
- Reset: hold rst=0 with toggling inputs → out_valid=0, in_ready=0, match_addr=0, match_count=0. First cycle after release → in_ready=1.
- Single match: capture row_match_vec=16'h0020 with out_ready=1 → the next cycle gives one beat: match_addr=5, match_found=1, match_count=1, last=1. The following cycle is IDLE with in_ready=1.
- Multi match with stall: capture 16'h8009, hold out_ready=0 for 3 cycles → match_addr stays 0 and out_valid stays 1. Then set out_ready=1 → beats addr 0, 3, 15 in that order; last=1 only on addr 15; match_count=3 on every beat.
- No match: capture 16'h0000 → one beat: match_found=0, match_count=0, last=1, match_addr=0.
- Full vector: capture 16'hFFFF with out_ready=1 → 16 consecutive beats, addr 0..15, match_count=16, last only on addr 15. in_ready stays 0 throughout, and match_in_valid pulsed mid-burst is ignored.
- Reset mid-burst: capture 16'h00F0, accept 1 beat (addr 4), then assert rst=0 → out_valid falls immediately (asynchronous). After release, the block is in IDLE and no stale beats for rows 5..7 appear.

Source files
------------

// File: rtl/cam_match_resolver_if.sv
// Handshake bundle between the CAM row array, the match resolver and the
// downstream lookup/update logic. The capture side carries the raw match
// lines. The result side carries one matching row address per beat.
interface cam_match_resolver_if #(
  parameter int NUM_ROWS = 16,
  parameter int ADDR_W   = 4
);
  logic                match_in_valid;
  logic [NUM_ROWS-1:0] row_match_vec;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [ADDR_W-1:0]   match_addr;
  logic                match_found;
  logic [ADDR_W:0]     match_count;
  logic                last;

  // Producer of search results and consumer of resolved beats.
  modport master (
    output match_in_valid, row_match_vec, out_ready,
    input  in_ready, out_valid, match_addr, match_found, match_count, last
  );

  // The resolver itself.
  modport slave (
    input  match_in_valid, row_match_vec, out_ready,
    output in_ready, out_valid, match_addr, match_found, match_count, last
  );
endinterface

// File: rtl/cam_match_resolver.sv
// CAM match resolver. It captures one search-result vector, then emits the
// matching row addresses lowest-row-first. There is one address per output
// handshake. Every result-side output comes straight from a flop, or from
// a decode of flops, so no input reaches an output combinationally.
module cam_match_resolver #(
  parameter int NUM_ROWS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,   // asynchronous, active low
  cam_match_resolver_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              state_q, state_d;
  logic                alive_q, alive_d;
  logic [NUM_ROWS-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                found_q, found_d;
  logic                last_q, last_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [NUM_ROWS-1:0] pending_cleared;

  // Index of the lowest set bit. An all-zero vector yields 0.
  function automatic logic [ADDR_W-1:0] lowest_idx(input logic [NUM_ROWS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ADDR_W'(i);
    end
  endfunction

  // Number of set bits. It needs ADDR_W+1 bits so a full vector fits.
  function automatic logic [ADDR_W:0] popcount(input logic [NUM_ROWS-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      popcount = popcount + (ADDR_W+1)'(v[i]);
    end
  endfunction

  // True when at most one bit is set, meaning the beat is the final one.
  function automatic logic at_most_one(input logic [NUM_ROWS-1:0] v);
    at_most_one = ((v & (v - NUM_ROWS'(1))) == '0);
  endfunction

  // Pending vector with its lowest set bit removed.
  assign pending_cleared = pending_q & (pending_q - NUM_ROWS'(1));

  // Next-state logic: capture in IDLE, walk the pending bits in EMIT.
  always_comb begin
    state_d   = state_q;
    alive_d   = 1'b1;
    pending_d = pending_q;
    addr_d    = addr_q;
    found_d   = found_q;
    last_d    = last_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (alive_q && bus.match_in_valid) begin
          state_d   = EMIT;
          pending_d = bus.row_match_vec;
          count_d   = popcount(bus.row_match_vec);
          addr_d    = lowest_idx(bus.row_match_vec);
          found_d   = |bus.row_match_vec;
          last_d    = at_most_one(bus.row_match_vec);
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (last_q) begin
            // The final beat has gone. Clear the beat fields but keep the
            // count of the finished result.
            state_d   = IDLE;
            pending_d = '0;
            addr_d    = '0;
            found_d   = 1'b0;
            last_d    = 1'b0;
          end else begin
            pending_d = pending_cleared;
            addr_d    = lowest_idx(pending_cleared);
            found_d   = 1'b1;
            last_d    = at_most_one(pending_cleared);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers. Reset clears them at once, so a burst in
  // flight is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      alive_q   <= 1'b0;
      pending_q <= '0;
      addr_q    <= '0;
      found_q   <= 1'b0;
      last_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      alive_q   <= alive_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      found_q   <= found_d;
      last_q    <= last_d;
      count_q   <= count_d;
    end
  end

  // alive_q keeps in_ready low until the first clock edge after reset.
  assign bus.in_ready    = alive_q && (state_q == IDLE);
  assign bus.out_valid   = (state_q == EMIT);
  assign bus.match_addr  = addr_q;
  assign bus.match_found = found_q;
  assign bus.match_count = count_q;
  assign bus.last        = last_q;

endmodule

// File: tb/tb_cam_match_resolver.sv
// Bench for cam_match_resolver. Each capture pushes its expected beats onto
// a scoreboard queue. A negedge monitor pops and compares every beat it sees.
module tb_cam_match_resolver;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [3:0] addr;
    logic       found;
    logic [4:0] count;
    logic       last;
  } beat_t;

  beat_t sq[$];

  cam_match_resolver_if #(.NUM_ROWS(16), .ADDR_W(4)) bus ();

  cam_match_resolver #(.NUM_ROWS(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Build the expected beat list for one captured vector.
  task automatic push_expected(input logic [15:0] v);
    int n;
    int k;
    beat_t b;
    n = $countones(v);
    k = 0;
    if (n == 0) begin
      b = '{addr: 4'd0, found: 1'b0, count: 5'd0, last: 1'b1};
      sq.push_back(b);
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (v[i]) begin
          k++;
          b.addr  = 4'(i);
          b.found = 1'b1;
          b.count = 5'(n);
          b.last  = (k == n);
          sq.push_back(b);
        end
      end
    end
  endtask

  // Scoreboard monitor. A beat transfers at the next posedge when valid
  // and ready are both high here.
  always @(negedge clk) begin
    beat_t e;
    if (rst && bus.out_valid && bus.out_ready) begin
      if (sq.size() == 0) begin
        chk("spurious_beat_addr", {28'd0, bus.match_addr}, 32'hFFFF_FFFF);
      end else begin
        e = sq.pop_front();
        $display("beat addr=%0d found=%0d count=%0d last=%0d", bus.match_addr,
                 bus.match_found, bus.match_count, bus.last);
        chk("beat_addr",  bus.match_addr,  e.addr);
        chk("beat_found", bus.match_found, e.found);
        chk("beat_count", bus.match_count, e.count);
        chk("beat_last",  bus.last,        e.last);
      end
    end
  end

  // Capture one vector. This returns at the negedge after the capture edge.
  task automatic send(input logic [15:0] v);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", bus.in_ready, 1);
    bus.match_in_valid = 1'b1;
    bus.row_match_vec  = v;
    push_expected(v);
    $display("capture vec=%h", v);
    @(posedge clk);
    #1 bus.match_in_valid = 1'b0;
    @(negedge clk);
    chk("cap_latency", bus.out_valid, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.in_ready && !bus.out_valid) && n < 200);
    chk("idle_reached", bus.in_ready & ~bus.out_valid, 1);
  endtask

  initial begin
    rst                = 1'b0;
    bus.match_in_valid = 1'b0;
    bus.row_match_vec  = '0;
    bus.out_ready      = 1'b0;

    // Hold reset while the inputs toggle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.match_in_valid = i[0];
      bus.row_match_vec  = 16'($urandom);
      bus.out_ready      = ~i[0];
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready",  bus.in_ready, 0);
      chk("rst_addr",      bus.match_addr, 0);
      chk("rst_count",     bus.match_count, 0);
      chk("rst_found",     bus.match_found, 0);
      chk("rst_last",      bus.last, 0);
    end
    @(negedge clk);
    bus.match_in_valid = 1'b0;
    bus.row_match_vec  = '0;
    bus.out_ready      = 1'b0;
    #2 rst = 1'b1;
    #1 chk("release_in_ready_low", bus.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Single match.
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(16'h0020);
    @(negedge clk);
    chk("single_idle_in_ready", bus.in_ready, 1);
    chk("single_idle_valid", bus.out_valid, 0);

    // Multi match with a three-cycle stall.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(16'h8009);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_addr",  bus.match_addr, 0);
      chk("stall_count", bus.match_count, 3);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_idle();

    // No match.
    send(16'h0000);
    wait_idle();

    // Full vector, with a capture attempt in the middle of the burst.
    send(16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.match_in_valid = 1'b1;
    bus.row_match_vec  = 16'h1234;
    @(negedge clk);
    chk("full_pulse_in_ready", bus.in_ready, 0);
    bus.match_in_valid = 1'b0;
    bus.row_match_vec  = '0;
    wait_idle();

    // Reset in the middle of a burst.
    send(16'h00F0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_valid_pre", bus.out_valid, 1);
    #1 rst = 1'b0;
    #1 chk("mid_async_valid", bus.out_valid, 0);
    sq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale_valid", bus.out_valid, 0);
    end
    chk("mid_idle_in_ready", bus.in_ready, 1);

    chk("sb_left", sq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
